sample_clk_sequencer: RTL and testbench
=======================================

// Module: sample_clk_sequencer
// PURPOSE
//  Programmable sample-clock controller for the detector acquisition path. It replaces the
//  fixed divide-by-128 stage with a run-time configurable divider. Start, stop and burst are
//  sequenced by the control logic; clk_out is always a clean, untruncated 50% waveform.
//  A one-cycle sample strobe is emitted per period for the ADC/ANC datapath.
// PARAMETERS
//  CNT_W         16   width of half-period count (cfg_half, active_half)
//  BURST_W       16   width of burst length and period counter
//  DEFAULT_HALF  64   half-period (clk cycles) after reset; 64 => divide-by-128
// PORTS
//  clk          in   1        system clock
//  rst          in   1        reset, asynchronous, active-high
//  start        in   1        pulse/level; begins a run when IDLE
//  stop         in   1        requests graceful stop when running
//  burst_len    in   BURST_W  periods per run, sampled at start; 0 = continuous
//  cfg_valid    in   1        new half-period offered
//  cfg_ready    out  1        config accept; transfer when cfg_valid & cfg_ready
//  cfg_half     in   CNT_W    requested half-period in clk cycles; 0 treated as 1
//  clk_out      out  1        divided clock, registered
//  sample_stb   out  1        1-cycle pulse coincident with each clk_out 0->1
//  busy         out  1        state != IDLE
//  done         out  1        1-cycle pulse when a run ends
//  period_cnt   out  BURST_W  periods started in current run (wraps in continuous mode)
//  active_half  out  CNT_W    half-period currently in use
// BEHAVIOUR
//  Reset: IDLE, clk_out=0, sample_stb=0, done=0, busy=0, cfg_ready=1, count=0,
//   period_cnt=0, active_half=DEFAULT_HALF, pending flag clear, stop_pend clear.
//  States: IDLE, RUN, STOPPING.
//  IDLE: clk_out=0. cfg handshake loads active_half=max(cfg_half,1) on the accepting edge.
//   start=1: next cycle state=RUN, clk_out=1, sample_stb=1, count=0, period_cnt=1,
//   burst latched. Latency start->clk_out high = 1 cycle. stop in IDLE ignored;
//   start+stop together in IDLE => start wins. start+cfg together: cfg applied first, used.
//  RUN/STOPPING: count increments every cycle; at count==active_half-1: count<=0, clk_out
//   toggles. Each half lasts exactly active_half cycles.
//   0->1 toggle (period boundary): sample_stb=1, period_cnt+1; pending cfg applied here,
//   so both halves of any period always use the same divisor.
//  Reconfig while busy: accepted value goes to pending reg; cfg_ready=0 from next cycle
//   until the period boundary that applies it; cfg_ready=1 again the cycle after.
//  End of run: at end of a low half (count==active_half-1, clk_out=0) when
//   (burst_len!=0 and period_cnt==burst_len) or in STOPPING: next cycle state=IDLE,
//   clk_out stays 0, no strobe, done=1 for that one cycle, busy=0. A pending cfg still
//   unapplied at that point is applied on entry to IDLE.
//  stop in RUN: go STOPPING; current period completes (high and low halves), no new period.
//   start during RUN/STOPPING ignored; stop+start in RUN => stop wins.
//  Half=1: clk_out toggles every cycle (divide-by-2); strobe every 2 cycles.
//  Async rst mid-run: all outputs return to reset values immediately; no done pulse.
// TESTING
//  1 reset, start, burst_len=0 -> clk_out high 64 / low 64 forever; stb cycle 1, 129, 257.
//  2 cfg_half=2, burst_len=3, start at cycle 0 -> clk_out 1100 x3 on cycles 1-12;
//    stb cycles 1,5,9; done=1 and busy=0 at cycle 13.
//  3 half=4 running, write cfg_half=2 at 2nd high cycle -> cfg_ready low until boundary;
//    current period 4/4, next periods 2/2; active_half=2 from that boundary.
//  4 half=8, stop at 3rd high cycle -> remaining high + 8 low cycles, then IDLE, done
//    pulse, no further stb.
//  5 cfg_half=0 -> active_half=1; clk_out toggles every cycle; stb every 2 cycles.
//  6 rst asserted mid high phase -> clk_out=0, busy=0 same cycle; active_half=64, no done.

Source files
------------

// File: rtl/sample_clk_sequencer_if.sv
// Control/config/status bundle for the programmable sample-clock sequencer.
// The master drives run control and configuration; the slave returns the divided clock and status.
interface sample_clk_sequencer_if #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 16
);
  logic               start;
  logic               stop;
  logic [BURST_W-1:0] burst_len;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_half;
  logic               clk_out;
  logic               sample_stb;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] period_cnt;
  logic [CNT_W-1:0]   active_half;

  modport master (
    output start, stop, burst_len, cfg_valid, cfg_half,
    input  cfg_ready, clk_out, sample_stb, busy, done, period_cnt, active_half
  );

  modport slave (
    input  start, stop, burst_len, cfg_valid, cfg_half,
    output cfg_ready, clk_out, sample_stb, busy, done, period_cnt, active_half
  );
endinterface

// File: rtl/sample_clk_sequencer.sv
// Run-time programmable sample-clock divider with start/stop/burst sequencing.
// clk_out is always a whole 50% waveform; a divisor change only takes effect at a period boundary.
module sample_clk_sequencer #(
  parameter int CNT_W        = 16,
  parameter int BURST_W      = 16,
  parameter int DEFAULT_HALF = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  sample_clk_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   HALF_RESET = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BST_ZERO   = {BURST_W{1'b0}};
  localparam logic [BURST_W-1:0] BST_ONE    = {{(BURST_W-1){1'b0}}, 1'b1};

  // A zero half-period would never toggle, so it is promoted to the fastest legal divisor.
  function automatic logic [CNT_W-1:0] clamp_half(input logic [CNT_W-1:0] half);
    if (half == CNT_ZERO) begin
      clamp_half = CNT_ONE;
    end else begin
      clamp_half = half;
    end
  endfunction

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic               clk_out_r, clk_out_s;
  logic               stb_r, stb_s;
  logic               done_r, done_s;
  logic               busy_r, busy_s;
  logic               cfg_ready_r, cfg_ready_s;
  logic [BURST_W-1:0] period_cnt_r, period_cnt_s;
  logic [CNT_W-1:0]   active_half_r, active_half_s;
  logic               pend_r, pend_s;
  logic [CNT_W-1:0]   pend_half_r, pend_half_s;
  logic [BURST_W-1:0] burst_r, burst_s;

  logic               cfg_fire_s;
  logic [CNT_W-1:0]   cfg_half_s;
  logic               half_end_s;
  logic               run_end_s;

  assign cfg_fire_s = bus.cfg_valid & cfg_ready_r;
  assign cfg_half_s = clamp_half(bus.cfg_half);
  assign half_end_s = (count_r == (active_half_r - CNT_ONE));
  // A stop seen on the final low cycle ends the run right there instead of opening a new period.
  assign run_end_s  = ((burst_r != BST_ZERO) && (period_cnt_r == burst_r)) ||
                      (state_r == ST_STOPPING) || bus.stop;

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_s       = state_r;
    count_s       = count_r;
    clk_out_s     = clk_out_r;
    stb_s         = 1'b0;
    done_s        = 1'b0;
    period_cnt_s  = period_cnt_r;
    active_half_s = active_half_r;
    pend_s        = pend_r;
    pend_half_s   = pend_half_r;
    burst_s       = burst_r;
    case (state_r)
      ST_IDLE: begin
        count_s   = CNT_ZERO;
        clk_out_s = 1'b0;
        if (cfg_fire_s) begin
          active_half_s = cfg_half_s;
        end else begin
          active_half_s = active_half_r;
        end
        if (bus.start) begin
          state_s      = ST_RUN;
          clk_out_s    = 1'b1;
          stb_s        = 1'b1;
          period_cnt_s = BST_ONE;
          burst_s      = bus.burst_len;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN, ST_STOPPING: begin
        if ((state_r == ST_RUN) && bus.stop) begin
          state_s = ST_STOPPING;
        end else begin
          state_s = state_r;
        end
        if (cfg_fire_s) begin
          pend_s      = 1'b1;
          pend_half_s = cfg_half_s;
        end else begin
          pend_s      = pend_r;
          pend_half_s = pend_half_r;
        end
        if (!half_end_s) begin
          count_s = count_r + CNT_ONE;
        end else if (clk_out_r) begin
          count_s   = CNT_ZERO;
          clk_out_s = 1'b0;
        end else if (run_end_s) begin
          count_s   = CNT_ZERO;
          clk_out_s = 1'b0;
          state_s   = ST_IDLE;
          done_s    = 1'b1;
          if (cfg_fire_s) begin
            active_half_s = cfg_half_s;
            pend_s        = 1'b0;
          end else if (pend_r) begin
            active_half_s = pend_half_r;
            pend_s        = 1'b0;
          end else begin
            active_half_s = active_half_r;
          end
        end else begin
          // Period boundary: the only point where a pending divisor may take over.
          count_s      = CNT_ZERO;
          clk_out_s    = 1'b1;
          stb_s        = 1'b1;
          period_cnt_s = period_cnt_r + BST_ONE;
          if (pend_r) begin
            active_half_s = pend_half_r;
            pend_s        = 1'b0;
          end else begin
            active_half_s = active_half_r;
          end
        end
      end
      default: begin
        state_s   = ST_IDLE;
        count_s   = CNT_ZERO;
        clk_out_s = 1'b0;
      end
    endcase
    cfg_ready_s = ~pend_s;
    busy_s      = (state_s != ST_IDLE);
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      count_r       <= CNT_ZERO;
      clk_out_r     <= 1'b0;
      stb_r         <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
      cfg_ready_r   <= 1'b1;
      period_cnt_r  <= BST_ZERO;
      active_half_r <= HALF_RESET;
      pend_r        <= 1'b0;
      pend_half_r   <= HALF_RESET;
      burst_r       <= BST_ZERO;
    end else begin
      state_r       <= state_s;
      count_r       <= count_s;
      clk_out_r     <= clk_out_s;
      stb_r         <= stb_s;
      done_r        <= done_s;
      busy_r        <= busy_s;
      cfg_ready_r   <= cfg_ready_s;
      period_cnt_r  <= period_cnt_s;
      active_half_r <= active_half_s;
      pend_r        <= pend_s;
      pend_half_r   <= pend_half_s;
      burst_r       <= burst_s;
    end
  end

  assign bus.clk_out     = clk_out_r;
  assign bus.sample_stb  = stb_r;
  assign bus.done        = done_r;
  assign bus.busy        = busy_r;
  assign bus.cfg_ready   = cfg_ready_r;
  assign bus.period_cnt  = period_cnt_r;
  assign bus.active_half = active_half_r;

endmodule

// File: tb/tb_sample_clk_sequencer.sv
// Self-checking bench for sample_clk_sequencer: expected waveforms are built period by period
// from the divisor rules and compared cycle by cycle, one sample #1 after each rising edge.
module tb_sample_clk_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bit exp_clk[$];
  bit exp_stb[$];

  sample_clk_sequencer_if #(.CNT_W(16), .BURST_W(16)) bus ();

  sample_clk_sequencer #(.CNT_W(16), .BURST_W(16), .DEFAULT_HALF(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    exp_clk.delete();
    exp_stb.delete();
  endtask

  // One whole period: h high cycles (strobe on the first), then h low cycles.
  task automatic model_period(input int h);
    for (int i = 0; i < 2 * h; i++) begin
      exp_clk.push_back(i < h);
      exp_stb.push_back(i == 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cfg(input int half);
    step();
    bus.cfg_valid = 1'b1;
    bus.cfg_half  = 16'(half);
    step();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [36:0] got;
    step();
    got = {bus.clk_out, bus.sample_stb, bus.done, bus.busy, bus.cfg_ready, bus.period_cnt, bus.active_half};
    checks++;
    if (got !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd64}) begin
      errors++; $display("FAIL reset_state got %h exp %h", got, {5'b00001, 16'd0, 16'd64});
    end
    rst = 1'b0;
    repeat (3) step();
    got = {bus.clk_out, bus.sample_stb, bus.done, bus.busy, bus.cfg_ready, bus.period_cnt, bus.active_half};
    checks++;
    if (got !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd64}) begin
      errors++; $display("FAIL idle_after_reset got %h exp %h", got, {5'b00001, 16'd0, 16'd64});
    end
  endtask

  task automatic test_continuous();
    logic [3:0] exp;
    logic [3:0] got;
    int len;
    model_clear();
    repeat (3) model_period(64);
    len = exp_clk.size();
    step();
    bus.burst_len = 16'd0;
    bus.start     = 1'b1;
    for (int c = 1; c <= len + 2; c++) begin
      step();
      bus.start = 1'b0;
      bus.stop  = (c == 301);
      if (c <= len) exp = {exp_clk[c-1], exp_stb[c-1], 1'b1, 1'b0};
      else if (c == len + 1) exp = 4'b0001;
      else exp = 4'b0000;
      got = {bus.clk_out, bus.sample_stb, bus.busy, bus.done};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL continuous_wave cycle %0d got %b exp %b", c, got, exp);
      end
    end
    bus.stop = 1'b0;
    checks++;
    if (bus.period_cnt !== 16'd3) begin
      errors++; $display("FAIL continuous_periods got %0d exp 3", bus.period_cnt);
    end
  endtask

  task automatic test_burst();
    logic [3:0] exp;
    logic [3:0] got;
    int len;
    idle_cfg(2);
    checks++;
    if (bus.active_half !== 16'd2) begin
      errors++; $display("FAIL burst_cfg_load got %0d exp 2", bus.active_half);
    end
    model_clear();
    repeat (3) model_period(2);
    len = exp_clk.size();
    bus.burst_len = 16'd3;
    bus.start     = 1'b1;
    for (int c = 1; c <= len + 2; c++) begin
      step();
      bus.start = (c == 6);
      if (c <= len) exp = {exp_clk[c-1], exp_stb[c-1], 1'b1, 1'b0};
      else if (c == len + 1) exp = 4'b0001;
      else exp = 4'b0000;
      got = {bus.clk_out, bus.sample_stb, bus.busy, bus.done};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL burst_wave cycle %0d got %b exp %b", c, got, exp);
      end
    end
    checks++;
    if (bus.period_cnt !== 16'd3) begin
      errors++; $display("FAIL burst_periods got %0d exp 3", bus.period_cnt);
    end
  endtask

  task automatic test_start_with_cfg_and_stop();
    logic [3:0] exp;
    logic [3:0] got;
    int len;
    model_clear();
    repeat (2) model_period(3);
    len = exp_clk.size();
    step();
    bus.burst_len = 16'd2;
    bus.cfg_valid = 1'b1;
    bus.cfg_half  = 16'd3;
    bus.stop      = 1'b1;
    bus.start     = 1'b1;
    for (int c = 1; c <= len + 2; c++) begin
      step();
      bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_valid = 1'b0;
      if (c <= len) exp = {exp_clk[c-1], exp_stb[c-1], 1'b1, 1'b0};
      else if (c == len + 1) exp = 4'b0001;
      else exp = 4'b0000;
      got = {bus.clk_out, bus.sample_stb, bus.busy, bus.done};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL start_cfg_wave cycle %0d got %b exp %b", c, got, exp);
      end
    end
  endtask

  task automatic test_reconfig();
    logic [3:0]  exp;
    logic [3:0]  got;
    logic [16:0] exp_cfg;
    int len;
    idle_cfg(4);
    model_clear();
    model_period(4);
    model_period(2);
    len = exp_clk.size();
    bus.burst_len = 16'd0;
    bus.start     = 1'b1;
    for (int c = 1; c <= len + 2; c++) begin
      step();
      bus.start     = 1'b0;
      bus.cfg_valid = (c == 2);
      bus.cfg_half  = 16'd2;
      bus.stop      = (c == 10);
      if (c <= len) exp = {exp_clk[c-1], exp_stb[c-1], 1'b1, 1'b0};
      else if (c == len + 1) exp = 4'b0001;
      else exp = 4'b0000;
      got = {bus.clk_out, bus.sample_stb, bus.busy, bus.done};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL reconfig_wave cycle %0d got %b exp %b", c, got, exp);
      end
      exp_cfg = {!(c >= 3 && c <= 8), (c <= 8) ? 16'd4 : 16'd2};
      checks++;
      if ({bus.cfg_ready, bus.active_half} !== exp_cfg) begin
        errors++; $display("FAIL reconfig_cfg cycle %0d got %h exp %h", c, {bus.cfg_ready, bus.active_half}, exp_cfg);
      end
    end
    bus.cfg_valid = 1'b0;
    bus.stop      = 1'b0;
  endtask

  task automatic test_stop();
    logic [3:0] exp;
    logic [3:0] got;
    int len;
    idle_cfg(8);
    model_clear();
    model_period(8);
    len = exp_clk.size();
    bus.burst_len = 16'd0;
    bus.start     = 1'b1;
    for (int c = 1; c <= len + 6; c++) begin
      step();
      bus.start = 1'b0;
      bus.stop  = (c == 3);
      if (c <= len) exp = {exp_clk[c-1], exp_stb[c-1], 1'b1, 1'b0};
      else if (c == len + 1) exp = 4'b0001;
      else exp = 4'b0000;
      got = {bus.clk_out, bus.sample_stb, bus.busy, bus.done};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL stop_wave cycle %0d got %b exp %b", c, got, exp);
      end
    end
  endtask

  task automatic test_half_one();
    logic [3:0] exp;
    logic [3:0] got;
    int len;
    idle_cfg(0);
    checks++;
    if (bus.active_half !== 16'd1) begin
      errors++; $display("FAIL half_zero_clamp got %0d exp 1", bus.active_half);
    end
    model_clear();
    repeat (4) model_period(1);
    len = exp_clk.size();
    bus.burst_len = 16'd4;
    bus.start     = 1'b1;
    for (int c = 1; c <= len + 2; c++) begin
      step();
      bus.start = 1'b0;
      if (c <= len) exp = {exp_clk[c-1], exp_stb[c-1], 1'b1, 1'b0};
      else if (c == len + 1) exp = 4'b0001;
      else exp = 4'b0000;
      got = {bus.clk_out, bus.sample_stb, bus.busy, bus.done};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL half_one_wave cycle %0d got %b exp %b", c, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] exp;
    logic [3:0] got;
    int len, h, h2_raw, h2, b;
    for (int it = 0; it < 8; it++) begin
      h      = int'($urandom_range(1, 5));
      h2_raw = int'($urandom_range(0, 5));
      h2     = (h2_raw == 0) ? 1 : h2_raw;
      b      = int'($urandom_range(1, 4));
      idle_cfg(h);
      model_clear();
      model_period(h);
      for (int p = 1; p < b; p++) model_period(h2);
      len = exp_clk.size();
      bus.burst_len = 16'(b);
      bus.start     = 1'b1;
      for (int c = 1; c <= len + 2; c++) begin
        step();
        bus.start     = 1'b0;
        bus.cfg_valid = (c == 1);
        bus.cfg_half  = 16'(h2_raw);
        if (c <= len) exp = {exp_clk[c-1], exp_stb[c-1], 1'b1, 1'b0};
        else if (c == len + 1) exp = 4'b0001;
        else exp = 4'b0000;
        got = {bus.clk_out, bus.sample_stb, bus.busy, bus.done};
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL random_wave it %0d h %0d h2 %0d b %0d cycle %0d got %b exp %b", it, h, h2, b, c, got, exp);
        end
      end
      checks++;
      if ({bus.period_cnt, bus.active_half} !== {16'(b), 16'(h2)}) begin
        errors++; $display("FAIL random_final it %0d got cnt %0d half %0d exp cnt %0d half %0d", it, bus.period_cnt, bus.active_half, b, h2);
      end
    end
  endtask

  task automatic test_rst_mid_run();
    logic [36:0] got;
    idle_cfg(20);
    bus.burst_len = 16'd0;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    #2;
    rst = 1'b1;
    #1;
    got = {bus.clk_out, bus.sample_stb, bus.done, bus.busy, bus.cfg_ready, bus.period_cnt, bus.active_half};
    checks++;
    if (got !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 16'd64}) begin
      errors++; $display("FAIL async_reset got %h exp %h", got, {5'b00001, 16'd0, 16'd64});
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if ({bus.done, bus.busy, bus.clk_out} !== 3'b000) begin
        errors++; $display("FAIL post_reset_quiet cycle %0d got %b exp 000", c, {bus.done, bus.busy, bus.clk_out});
      end
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.burst_len = 16'd0;
    bus.cfg_valid = 1'b0;
    bus.cfg_half  = 16'd0;
    test_reset();
    test_continuous();
    test_burst();
    test_start_with_cfg_and_stop();
    test_reconfig();
    test_stop();
    test_half_one();
    test_random();
    test_rst_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
